// File: rtl/unscript_status_sender.sv
// Packs an 8-bit status word into two tagged UART bytes and sends them over valid/ready.
// A frame is sent on status change, on a pending mid-frame change, or on heartbeat expiry.
module unscript_status_sender #(
    parameter logic [23:0] HEARTBEAT_CYCLES = 24'd9_600_000,
    parameter logic [1:0]  TAG_LO           = 2'b10,
    parameter logic [1:0]  TAG_HI           = 2'b11
) (
    input  logic       uart_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] status_in,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic [1:0] seq
);

    typedef enum logic [1:0] {StIdle, StSendLo, StSendHi} state_e;

    state_e      state_q, state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic [1:0]  seq_q, seq_d;
    logic [7:0]  last_sent_q, last_sent_d;
    logic [7:0]  snapshot_q, snapshot_d;
    logic [23:0] hb_cnt_q, hb_cnt_d;
    logic        dirty_q, dirty_d;

    logic [23:0] hb_max;
    logic        hb_expire;
    logic        changed;
    logic        trig;
    logic        accept;

    always_comb begin
        hb_max    = HEARTBEAT_CYCLES - 24'd1;
        // A zero period would make hb_max all-ones; suppress expiry entirely instead.
        hb_expire = (HEARTBEAT_CYCLES != 24'd0) && (hb_cnt_q == hb_max);
        changed   = (status_in != last_sent_q);
        trig      = enable && (changed || hb_expire || dirty_q);
        accept    = tx_valid_q && tx_ready;

        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        seq_d       = seq_q;
        last_sent_d = last_sent_q;
        snapshot_d  = snapshot_q;
        hb_cnt_d    = hb_cnt_q;
        dirty_d     = dirty_q;

        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    snapshot_d  = status_in;
                    last_sent_d = status_in;
                    dirty_d     = 1'b0;
                    hb_cnt_d    = 24'd0;
                    tx_data_d   = {seq_q, status_in[3:0], TAG_LO};
                    tx_valid_d  = 1'b1;
                    state_d     = StSendLo;
                end else if (enable && (hb_cnt_q != hb_max)) begin
                    hb_cnt_d = hb_cnt_q + 24'd1;
                end
            end
            StSendLo: begin
                if (changed) dirty_d = 1'b1;
                if (accept) begin
                    tx_data_d = {seq_q, snapshot_q[7:4], TAG_HI};
                    state_d   = StSendHi;
                end
            end
            StSendHi: begin
                if (changed) dirty_d = 1'b1;
                if (accept) begin
                    tx_valid_d = 1'b0;
                    seq_d      = seq_q + 2'd1;
                    state_d    = StIdle;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            seq_q       <= 2'd0;
            last_sent_q <= 8'h00;
            snapshot_q  <= 8'h00;
            hb_cnt_q    <= 24'd0;
            dirty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            seq_q       <= seq_d;
            last_sent_q <= last_sent_d;
            snapshot_q  <= snapshot_d;
            hb_cnt_q    <= hb_cnt_d;
            dirty_q     <= dirty_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign seq      = seq_q;

endmodule
